// File: rtl/ct_spsram_init_param.sv
// Parametrised single-port SRAM wrapper with post-reset zero-fill sweep,
// optional output register and a read-data hold stage.
module ct_spsram_init_param #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 196,
  parameter int OUT_REG    = 0,
  parameter int INIT_EN    = 1
) (
  input  logic                  CLK,
  input  logic                  cpurst_b,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic                  CEN,
  input  logic                  GWEN,
  input  logic [DATA_WIDTH-1:0] WEN,
  input  logic [DATA_WIDTH-1:0] D,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  INIT_DONE
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LAST_ADDR = {1'b0, {ADDR_WIDTH{1'b1}}};

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH:0]   r_init_cnt;
  logic                  w_sweep;
  logic                  w_init_done;

  logic                  w_cen_int;
  logic                  w_gwen_int;
  logic [DATA_WIDTH-1:0] w_wen_int;
  logic [ADDR_WIDTH-1:0] w_a_int;
  logic [DATA_WIDTH-1:0] w_d_int;
  logic                  w_req;
  logic                  w_we;
  logic [DATA_WIDTH-1:0] w_be;
  logic                  w_rd;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_macro_q;
  logic [DATA_WIDTH-1:0] r_q;

  // FSM: state register
  always_ff @(posedge CLK or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_state <= (INIT_EN != 0) ? ST_INIT : ST_READY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM: next state; the sweep leaves INIT on the edge that writes the last address
  always_comb begin
    w_state_next = r_state;
    if (r_state == ST_INIT && r_init_cnt == LAST_ADDR) begin
      w_state_next = ST_READY;
    end
  end

  // FSM: outputs
  always_comb begin
    w_sweep     = (r_state == ST_INIT) && !r_init_cnt[ADDR_WIDTH];
    w_init_done = (r_state == ST_READY);
  end

  assign INIT_DONE = w_init_done;

  always_ff @(posedge CLK or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_init_cnt <= '0;
    end else if (w_sweep) begin
      r_init_cnt <= r_init_cnt + 1'b1;
    end
  end

  // While not READY the external port is muxed off entirely
  always_comb begin
    w_cen_int  = CEN;
    w_gwen_int = GWEN;
    w_wen_int  = WEN;
    w_a_int    = A;
    w_d_int    = D;
    if (w_sweep) begin
      w_cen_int  = 1'b0;
      w_gwen_int = 1'b0;
      w_wen_int  = '0;
      w_a_int    = r_init_cnt[ADDR_WIDTH-1:0];
      w_d_int    = '0;
    end else if (!w_init_done) begin
      w_cen_int  = 1'b1;
      w_gwen_int = 1'b1;
      w_wen_int  = '1;
    end
  end

  assign w_req = ~w_cen_int;
  assign w_we  = ~w_gwen_int;
  assign w_be  = ~w_wen_int;
  assign w_rd  = w_req && !w_we;

  // Macro core: bit-enabled write, registered read (latency 1)
  always_ff @(posedge CLK) begin
    if (w_req && w_we) begin
      for (int i = 0; i < DATA_WIDTH; i++) begin
        if (w_be[i]) begin
          r_mem[w_a_int][i] <= w_d_int[i];
        end
      end
    end
    if (w_rd) begin
      r_macro_q <= r_mem[w_a_int];
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic                  r_vld1;
      logic                  r_vld2;
      logic [DATA_WIDTH-1:0] r_pipe_q;

      always_ff @(posedge CLK or negedge cpurst_b) begin
        if (!cpurst_b) begin
          r_vld1   <= 1'b0;
          r_vld2   <= 1'b0;
          r_pipe_q <= '0;
          r_q      <= '0;
        end else begin
          r_vld1 <= w_rd;
          r_vld2 <= r_vld1;
          if (r_vld1) begin
            r_pipe_q <= r_macro_q;
          end
          if (r_vld2) begin
            r_q <= r_pipe_q;
          end
        end
      end
    end else begin : g_no_out_reg
      logic r_vld1;

      // Hold stage: Q only moves when a read completes
      always_ff @(posedge CLK or negedge cpurst_b) begin
        if (!cpurst_b) begin
          r_vld1 <= 1'b0;
          r_q    <= '0;
        end else begin
          r_vld1 <= w_rd;
          if (r_vld1) begin
            r_q <= r_macro_q;
          end
        end
      end
    end
  endgenerate

  assign Q = r_q;

endmodule
